// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants and entry type for the instruction fetch queue.
// Imported by the interface and the queue itself.
package instr_fetch_queue_pkg;

    localparam int WORD_W = 32;
    localparam int FQ_DEPTH = 4;
    localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch/decode handshake bundle around the fetch queue.
// master = fetch+decode side, slave = the queue.
interface instr_fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             PushValid;
    logic             PushReady;
    logic [WIDTH-1:0] PushPC;
    logic [WIDTH-1:0] PushInstr;
    logic             PopValid;
    logic             PopReady;
    logic [WIDTH-1:0] PopPC;
    logic [WIDTH-1:0] PopInstr;
    logic [CW-1:0]    Count;

    modport master (
        output PushValid, PushPC, PushInstr, PopReady,
        input  PushReady, PopValid, PopPC, PopInstr, Count
    );

    modport slave (
        input  PushValid, PushPC, PushInstr, PopReady,
        output PushReady, PopValid, PopPC, PopInstr, Count
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// First-word-fall-through queue of {PC+4, instruction} between fetch and decode.
// Flush drops all entries on a redirect; storage is only cleared by Reset.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Flush,
    instr_fetch_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fq_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full, empty;
    logic            push_fire, pop_fire;

    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    assign push_fire = q.PushValid && !full;
    assign pop_fire  = q.PopReady && !empty;

    // Next pointers/count; full is judged on the pre-edge count, so a
    // pop does not open room for a push in the same cycle.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (Flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_fire) wr_d = wr_q + PW'(1);
            if (pop_fire)  rd_d = rd_q + PW'(1);
            unique case ({push_fire, pop_fire})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; cleared on reset so the head never shows unknowns.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!Flush && push_fire) begin
            mem_q[wr_q] <= '{pc: q.PushPC, instr: q.PushInstr};
        end
    end

    // Head mux: empty queue presents PC 0 and a NOP.
    always_comb begin
        q.PopValid  = !empty;
        q.PushReady = !full;
        q.Count     = cnt_q;
        q.PopPC     = '0;
        q.PopInstr  = INSTR_NOP;
        if (!empty) begin
            q.PopPC    = mem_q[rd_q].pc;
            q.PopInstr = mem_q[rd_q].instr;
        end
    end

endmodule
